// File: rtl/io_port_bank_pkg.sv
// io_port_bank shared definitions: register map and status layout.
package io_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_PUSH   = 4'h9;
    localparam logic [3:0] ADDR_CLEAR  = 4'hA;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_CNT   = 3;
    localparam int ST_NEW   = 8;

endpackage

// File: rtl/io_port_bank_if.sv
// CPU load/store bus and output stream handshake of io_port_bank.
interface io_port_bank_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [WIDTH-1:0]  cpu_wdata;
    logic [WIDTH-1:0]  cpu_rdata;
    logic [WIDTH-1:0]  stream_data;
    logic              stream_valid;
    logic              stream_ready;

    modport master (
        output cpu_addr, cpu_wr, cpu_rd, cpu_wdata, stream_ready,
        input  cpu_rdata, stream_data, stream_valid
    );

    modport slave (
        input  cpu_addr, cpu_wr, cpu_rd, cpu_wdata, stream_ready,
        output cpu_rdata, stream_data, stream_valid
    );
endinterface

// File: rtl/io_port_bank_fifo.sv
// Output stream FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
module io_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_pulse
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign full           = (count == CW'(DEPTH));
    assign empty          = (count == '0);
    assign do_pop         = pop & ~empty;
    assign do_push        = push & (~full | do_pop);
    assign overflow_pulse = push & full & ~do_pop;
    assign rdata          = mem[rp];

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wp] <= wdata;
    end
endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of synchronised input channels, output registers
// and a buffered output stream.
module io_port_bank
    import io_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 4
) (
    input  logic                    clock,
    input  logic                    rst,
    io_port_bank_if.slave           bus,
    input  logic [NUM_CH*WIDTH-1:0] read_in,
    output logic [NUM_CH*WIDTH-1:0] write_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef logic [NUM_CH-1:0][WIDTH-1:0] chv_t;

    chv_t              pins, s1, s2, prev, wo_q;
    logic [NUM_CH-1:0] new_q, new_d, chg, rd_ch, wr_ch;
    logic              ovf_q, ovf_d, ovf_pulse;
    logic              f_full, f_empty, push, pop, clr, is_stat;
    logic [CW-1:0]     f_count;
    logic [WIDTH-1:0]  rd_val, rdata_q;
    logic [15:0]       status;

    assign pins          = read_in;
    assign write_out     = wo_q;
    assign bus.cpu_rdata = rdata_q;

    assign is_stat = (bus.cpu_addr == ADDR_W'(ADDR_STATUS));
    assign push    = bus.cpu_wr && (bus.cpu_addr == ADDR_W'(ADDR_PUSH));
    assign clr     = bus.cpu_wr && (bus.cpu_addr == ADDR_W'(ADDR_CLEAR));
    assign pop     = bus.stream_valid && bus.stream_ready;
    assign bus.stream_valid = ~f_empty;

    always_comb begin
        chg   = '0;
        rd_ch = '0;
        wr_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            chg[i]   = (s2[i] != prev[i]);
            rd_ch[i] = bus.cpu_rd && (bus.cpu_addr == ADDR_W'(i));
            wr_ch[i] = bus.cpu_wr && (bus.cpu_addr == ADDR_W'(i));
        end
    end

    always_comb begin
        status                = '0;
        status[ST_EMPTY]      = f_empty;
        status[ST_FULL]       = f_full;
        status[ST_OVF]        = ovf_q;
        status[ST_CNT +: 5]   = 5'(f_count);
        status[ST_NEW +: 8]   = 8'(new_q);
        rd_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cpu_addr == ADDR_W'(i)) rd_val = s2[i];
        end
        if (is_stat) rd_val = WIDTH'(status);
    end

    // Clears are applied first so a same-cycle set always wins.
    always_comb begin
        new_d = new_q;
        ovf_d = ovf_q;
        if (clr) begin
            new_d = '0;
            ovf_d = 1'b0;
        end
        new_d = new_d & ~rd_ch;
        if (bus.cpu_rd && is_stat) ovf_d = 1'b0;
        new_d = new_d | chg;
        if (ovf_pulse) ovf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            s1      <= '0;
            s2      <= '0;
            prev    <= '0;
            wo_q    <= '0;
            new_q   <= '0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            s1    <= pins;
            s2    <= s1;
            prev  <= s2;
            new_q <= new_d;
            ovf_q <= ovf_d;
            if (bus.cpu_rd) rdata_q <= rd_val;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ch[i]) wo_q[i] <= bus.cpu_wdata;
            end
        end
    end

    io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock          (clock),
        .rst            (rst),
        .push           (push),
        .pop            (pop),
        .wdata          (bus.cpu_wdata),
        .rdata          (bus.stream_data),
        .full           (f_full),
        .empty          (f_empty),
        .count          (f_count),
        .overflow_pulse (ovf_pulse)
    );
endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: expected loads and stream pops are queued.
module tb_io_port_bank;
    localparam int W = 16;
    localparam int N = 4;
    localparam int D = 4;
    localparam int A = 4;

    logic           clock = 1'b0;
    logic           rst   = 1'b0;
    logic [N*W-1:0] read_in;
    logic [N*W-1:0] write_out;

    io_port_bank_if #(.WIDTH(W), .ADDR_W(A)) bus();

    io_port_bank #(
        .WIDTH(W), .NUM_CH(N), .FIFO_DEPTH(D), .ADDR_W(A)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .bus       (bus),
        .read_in   (read_in),
        .write_out (write_out)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] rd_q[$];
    logic [W-1:0] st_q[$];
    bit         rd_pend = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: loads are checked the negedge after the executing edge;
    // stream pops are checked at the negedge before the popping edge.
    always @(negedge clock) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_extra: got %h expected none", bus.cpu_rdata);
            end else begin
                chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(rd_q.pop_front()));
            end
        end
        rd_pend = rst && bus.cpu_rd;
        if (rst && bus.stream_valid && bus.stream_ready) begin
            if (st_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: got %h expected none", bus.stream_data);
            end else begin
                chk("stream_pop", 64'(bus.stream_data), 64'(st_q.pop_front()));
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic rd(logic [A-1:0] a, logic [W-1:0] exp);
        rd_q.push_back(exp);
        bus.cpu_addr = a;
        bus.cpu_rd   = 1'b1;
        @(posedge clock);
        #2;
        bus.cpu_rd = 1'b0;
    endtask

    task automatic wr(logic [A-1:0] a, logic [W-1:0] d);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_wr    = 1'b1;
        @(posedge clock);
        #2;
        bus.cpu_wr = 1'b0;
    endtask

    initial begin
        bus.cpu_addr     = '0;
        bus.cpu_wr       = 1'b0;
        bus.cpu_rd       = 1'b0;
        bus.cpu_wdata    = '0;
        bus.stream_ready = 1'b0;
        read_in          = '0;

        // 1: reset state
        #12;
        chk("rst_write_out", write_out, 64'h0);
        chk("rst_valid", 64'(bus.stream_valid), 64'h0);
        chk("rst_rdata", 64'(bus.cpu_rdata), 64'h0);
        @(posedge clock);
        #2;
        rst = 1'b1;
        rd(4'h8, 16'h0001);

        // 2: input change on channel 1
        read_in[31:16] = 16'h13b0;
        idle(3);
        rd(4'h8, 16'h0201);
        rd(4'h1, 16'h13b0);
        rd(4'h8, 16'h0001);

        // 3: output register store
        wr(4'h2, 16'h000b);
        chk("write_out", write_out, 64'h0000_000b_0000_0000);

        // 4: overflow and drain
        for (int i = 1; i <= 5; i++) wr(4'h9, W'(i));
        rd(4'h8, 16'h0026);
        for (int i = 1; i <= 4; i++) st_q.push_back(W'(i));
        bus.stream_ready = 1'b1;
        idle(4);
        bus.stream_ready = 1'b0;
        chk("drained_valid", 64'(bus.stream_valid), 64'h0);
        rd(4'h8, 16'h0001);

        // 5: push and pop together while full
        for (int i = 1; i <= 4; i++) wr(4'h9, W'(16'h00a0 + i));
        st_q.push_back(16'h00a1);
        bus.stream_ready = 1'b1;
        wr(4'h9, 16'h1234);
        bus.stream_ready = 1'b0;
        rd(4'h8, 16'h0022);
        st_q.push_back(16'h00a2);
        st_q.push_back(16'h00a3);
        st_q.push_back(16'h00a4);
        st_q.push_back(16'h1234);
        bus.stream_ready = 1'b1;
        idle(4);
        bus.stream_ready = 1'b0;

        // 6: asynchronous reset mid-drain
        read_in = '0;
        wr(4'h9, 16'h0055);
        wr(4'h9, 16'h0066);
        wr(4'h9, 16'h0077);
        chk("valid_before_rst", 64'(bus.stream_valid), 64'h1);
        st_q.push_back(16'h0055);
        bus.stream_ready = 1'b1;
        @(posedge clock);
        #2;
        rst = 1'b0;
        #1;
        chk("valid_async_drop", 64'(bus.stream_valid), 64'h0);
        chk("rst_write_out2", write_out, 64'h0);
        bus.stream_ready = 1'b0;
        idle(2);
        rst = 1'b1;
        rd(4'h8, 16'h0001);
        idle(1);

        chk("rd_q_drained", 64'(rd_q.size()), 64'h0);
        chk("st_q_drained", 64'(st_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
